// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - state_e   : sequencer states (IDLE -> ACCESS -> DONE)
//   - PORT_CPU  : index of the CPU load/store port (port 0)
//   - PORT_DBG  : index of the debug/DMA loader port (port 1)
//   - DW_DEF / AW_DEF / DEPTH_DEF : default data width, address width, depth
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req0_i       : request from port 0
//   req1_i       : request from port 1
//   last_grant_i : port granted most recently
//   grant_o      : winning port index (meaningful only when valid_o is high)
//   valid_o      : at least one request is pending
// On a tie the port that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        grant_o = PORT_CPU;
        if (req0_i && req1_i) begin
            grant_o = (last_grant_i == PORT_CPU) ? PORT_DBG : PORT_CPU;
        end else if (req1_i) begin
            grant_o = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the CPU port (p0) and the
// debug/DMA port (p1). Every access runs IDLE -> ACCESS -> DONE; all
// memory-side signals and all port outputs come straight from registers.
// Out-of-range addresses (addr >= DEPTH) never touch the memory and are
// reported through px_err together with px_ack.
//   clk, rst                 : clock, asynchronous active-high reset
//   px_req/px_we/px_addr/px_wdata : port request and command (x = 0,1)
//   px_ack/px_rdata/px_err   : one-cycle completion, read data, range error
//   mem_address/mem_write_data/mem_write_enable/mem_read_enable : to memory
//   mem_read_data            : combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_write_enable,
    output logic          mem_read_enable,
    input  logic [DW-1:0] mem_read_data
);

    state_e        state_q;
    logic          last_grant_q;
    logic          win_q;
    logic          we_q;
    logic          in_range_q;
    logic [1:0]    ack_q;
    logic [1:0]    err_q;
    logic [DW-1:0] rdata_q [2];
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic          mem_re_q;

    logic          arb_grant;
    logic          arb_valid;
    logic          sel_we_d;
    logic [AW-1:0] sel_addr_d;
    logic [DW-1:0] sel_wdata_d;
    logic          sel_in_range_d;

    rr_arb2 u_rr_arb2 (
        .req0_i       (p0_req),
        .req1_i       (p1_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    // Command of whichever port the arbiter picks this cycle.
    always_comb begin
        sel_we_d       = (arb_grant == PORT_DBG) ? p1_we    : p0_we;
        sel_addr_d     = (arb_grant == PORT_DBG) ? p1_addr  : p0_addr;
        sel_wdata_d    = (arb_grant == PORT_DBG) ? p1_wdata : p0_wdata;
        sel_in_range_d = (sel_addr_d < AW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DBG;   // port 0 wins the first tie
            win_q        <= PORT_CPU;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            // Pulse-type outputs fall back to zero unless a state sets them.
            ack_q       <= '0;
            err_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        win_q        <= arb_grant;
                        last_grant_q <= arb_grant;
                        we_q         <= sel_we_d;
                        in_range_q   <= sel_in_range_d;
                        state_q      <= ACCESS;
                        // Memory strobes are loaded here so they are
                        // registered during the ACCESS cycle.
                        if (sel_in_range_d) begin
                            mem_addr_q <= sel_addr_d;
                            mem_we_q   <= sel_we_d;
                            mem_re_q   <= ~sel_we_d;
                            if (sel_we_d) begin
                                mem_wdata_q <= sel_wdata_d;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!in_range_q) begin
                        rdata_q[win_q] <= '0;
                        err_q[win_q]   <= 1'b1;
                    end else if (!we_q) begin
                        rdata_q[win_q] <= mem_read_data;
                    end
                    ack_q[win_q] <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_ack           = ack_q[0];
    assign p1_ack           = ack_q[1];
    assign p0_err           = err_q[0];
    assign p1_err           = err_q[1];
    assign p0_rdata         = rdata_q[0];
    assign p1_rdata         = rdata_q[1];
    assign mem_address      = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

endmodule
